// File: rtl/sfifo_stream_reader.sv
// sfifo_stream_reader: drains an sfifo through a 2-entry skid buffer into a valid/ready stream with burst framing.
module sfifo_stream_reader #(
  parameter  int WIDTH     = 8,
  parameter  int BURST_LEN = 4,
  localparam int CNT_W     = $clog2(BURST_LEN)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_fifo_rd_en,
  input  logic             i_fifo_empty,
  input  logic [WIDTH-1:0] i_fifo_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic [CNT_W-1:0] o_beat_cnt,
  output logic [1:0]       o_level
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);
  state_t           state, state_n;
  logic [WIDTH-1:0] head, skid;
  logic [CNT_W-1:0] beat_cnt;
  logic             pop, hs, ld_head, from_skid, ld_skid;
  // rd_en comes from registered state only so the FIFO's pass-through empty cannot loop back
  assign o_fifo_rd_en = i_rst_n & (state != TWO);
  assign pop          = o_fifo_rd_en & ~i_fifo_empty;
  assign o_valid      = state != EMPTY;
  assign hs           = o_valid & i_ready;
  assign o_data       = head;
  assign o_beat_cnt   = beat_cnt;
  assign o_last       = o_valid & (beat_cnt == LAST_IDX);
  assign o_level      = state;
  always_comb begin
    state_n   = state;
    ld_head   = 1'b0;
    from_skid = 1'b0;
    ld_skid   = 1'b0;
    case (state)
      EMPTY: begin
        state_n = pop ? ONE : EMPTY;
        ld_head = pop;
      end
      ONE: begin
        state_n = (pop & ~hs) ? TWO : (~pop & hs) ? EMPTY : ONE;
        ld_head = pop & hs;
        ld_skid = pop & ~hs;
      end
      TWO: begin
        state_n   = hs ? ONE : TWO;
        ld_head   = hs;
        from_skid = 1'b1;
      end
      default: state_n = EMPTY;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= EMPTY;
      head     <= '0;
      skid     <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_n;
      if (ld_head) head <= from_skid ? skid : i_fifo_data;
      if (ld_skid) skid <= i_fifo_data;
      if (hs) beat_cnt <= (beat_cnt == LAST_IDX) ? '0 : beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sfifo_stream_reader.sv
// tb_sfifo_stream_reader: FIFO model plus scoreboard of expected beats (data and burst index) for sfifo_stream_reader.
module tb_sfifo_stream_reader;
  localparam int W  = 8;
  localparam int BL = 4;
  localparam int CW = 2;
  logic          i_clk = 1'b0, i_rst_n = 1'b1, o_fifo_rd_en, i_fifo_empty = 1'b1;
  logic          o_valid, i_ready = 1'b0, o_last;
  logic [W-1:0]  i_fifo_data = '0, o_data;
  logic [CW-1:0] o_beat_cnt;
  logic [1:0]    o_level;
  typedef struct {logic [W-1:0] d; int idx;} beat_t;
  logic [W-1:0]  fq[$];
  beat_t         sb[$];
  int            vecs = 0, errs = 0, lvl = 0, seq = 0, hs_n = 0;
  logic          held = 1'b0, h_l;
  logic [W-1:0]  h_d;
  logic [CW-1:0] h_c;

  sfifo_stream_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .o_fifo_rd_en(o_fifo_rd_en), .i_fifo_empty(i_fifo_empty),
    .i_fifo_data(i_fifo_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_last(o_last), .o_beat_cnt(o_beat_cnt), .o_level(o_level)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    fq.push_back(d);
    sb.push_back('{d, seq % BL});
    seq++;
  endtask

  task automatic step(input logic rdy);
    beat_t b;
    @(negedge i_clk);
    i_ready      = rdy;
    i_fifo_empty = fq.size() == 0;
    i_fifo_data  = i_fifo_empty ? '0 : fq[0];
    #1;
    chk("level", 32'(o_level), 32'(lvl));
    chk("valid", 32'(o_valid), 32'(lvl != 0));
    chk("rd_en", 32'(o_fifo_rd_en), 32'(lvl < 2));
    if (held) begin
      chk("hold_data", 32'(o_data), 32'(h_d));
      chk("hold_cnt", 32'(o_beat_cnt), 32'(h_c));
      chk("hold_last", 32'(o_last), 32'(h_l));
    end
    if (o_valid && i_ready) begin
      if (sb.size() == 0) chk("spurious_beat", 32'(1), 32'(0));
      else begin
        b = sb.pop_front();
        chk("data", 32'(o_data), 32'(b.d));
        chk("beat_cnt", 32'(o_beat_cnt), 32'(b.idx));
        chk("last", 32'(o_last), 32'(b.idx == BL - 1));
      end
      lvl--;
      hs_n++;
    end
    if (o_fifo_rd_en && !i_fifo_empty) begin
      void'(fq.pop_front());
      lvl++;
    end
    held = o_valid && !i_ready;
    h_d  = o_data;
    h_c  = o_beat_cnt;
    h_l  = o_last;
  endtask

  task automatic drain;
    for (int i = 0; i < 40 && sb.size() != 0; i++) step(1'b1);
    chk("drain_left", 32'(sb.size()), 32'(0));
  endtask

  task automatic do_reset;
    i_rst_n      = 1'b0;
    i_ready      = 1'b0;
    i_fifo_empty = 1'b1;
    fq.delete();
    sb.delete();
    lvl  = 0;
    seq  = 0;
    held = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid), 32'(0));
    chk("rst_data", 32'(o_data), 32'(0));
    chk("rst_last", 32'(o_last), 32'(0));
    chk("rst_cnt", 32'(o_beat_cnt), 32'(0));
    chk("rst_level", 32'(o_level), 32'(0));
    chk("rst_rd_en", 32'(o_fifo_rd_en), 32'(0));
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #2 do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    drain();
    @(negedge i_clk) do_reset();
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    repeat (5) step(1'b0);
    @(posedge i_clk); #1;
    chk("bp_level", 32'(o_level), 32'(2));
    chk("bp_rd_en", 32'(o_fifo_rd_en), 32'(0));
    chk("bp_data", 32'(o_data), 32'(8'hA0));
    hs_n = 0;
    repeat (6) step(1'b1);
    chk("bp_no_gap", 32'(hs_n), 32'(6));
    drain();
    @(negedge i_clk) do_reset();
    for (int i = 0; i < 10; i++) push(8'(i));
    for (int i = 0; i < 30 && sb.size() != 0; i++) step(i % 2 == 0);
    drain();
    @(negedge i_clk) do_reset();
    step(1'b0); step(1'b0);
    push(8'h5A);
    step(1'b0);
    @(posedge i_clk); #1;
    chk("pt_valid", 32'(o_valid), 32'(1));
    chk("pt_data", 32'(o_data), 32'(8'h5A));
    drain();
    @(negedge i_clk) do_reset();
    push(8'h30); push(8'h31);
    drain();
    repeat (4) step(1'b1);
    chk("gap_valid", 32'(o_valid), 32'(0));
    chk("gap_cnt", 32'(o_beat_cnt), 32'(2));
    push(8'h32); push(8'h33);
    drain();
    @(negedge i_clk) do_reset();
    for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
    repeat (3) step(1'b1);
    repeat (2) step(1'b0);
    @(posedge i_clk); #1;
    chk("mid_level", 32'(o_level), 32'(2));
    chk("mid_cnt", 32'(o_beat_cnt), 32'(2));
    do_reset();
    push(8'hC0); push(8'hC1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sfifo_stream_reader.md
Name: sfifo_stream_reader

Overview:
- Read-side consumer for the single-clock FIFO. Drains the FIFO through its rd_en/empty/data port and presents a valid/ready stream downstream.
- A 2-entry registered skid buffer gives full throughput while keeping o_fifo_rd_en free of any combinational dependency on i_fifo_empty or i_ready.
- Adds burst framing: o_last on every BURST_LEN-th accepted beat.
- Sits between an sfifo instance and any valid/ready sink (DMA, serializer, packet builder).

Parameters:
- WIDTH, 8, data width; must match the FIFO WIDTH.
- BURST_LEN, 4, beats per burst, ≥ 2; sets the o_last cadence.
- CNT_W, $clog2(BURST_LEN), width of the beat counter (derived localparam).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- o_fifo_rd_en  output  1  read request to the FIFO.
- i_fifo_empty  input  1  FIFO empty status, pass-through already accounted for.
- i_fifo_data  input  WIDTH  FIFO read data, valid in the same cycle as rd_en when not empty.
- o_valid  output  1  output beat valid.
- i_ready  input  1  downstream ready.
- o_data  output  WIDTH  output beat data.
- o_last  output  1  final beat of the current burst.
- o_beat_cnt  output  CNT_W  index of the current beat within its burst.
- o_level  output  2  occupancy of the skid buffer (0..2).

Behaviour:
- Reset (async, active-low): buffer count=0, o_valid=0, o_data=0, o_last=0, o_beat_cnt=0, o_level=0, o_fifo_rd_en=0. Reset mid-burst discards buffered beats and the beat count. The FIFO is not popped during reset.
- o_fifo_rd_en = (count < 2). It is a function of registered state only.
  - It must not depend combinationally on i_fifo_empty or i_ready. The FIFO's empty output depends on rd_en during pass-through, so such a dependency forms a combinational loop.
- pop = o_fifo_rd_en & ~i_fifo_empty. i_fifo_data is captured only on a pop. A rd_en with empty=1 has no effect.
- hs = o_valid & i_ready. o_valid = (count != 0). o_data/o_last come from the head register.
- Buffer states:
  - EMPTY (count=0):
    - pop → ONE, head <= data.
  - ONE (count=1):
    - pop & hs → ONE, head <= data.
    - pop & ~hs → TWO, skid <= data.
    - ~pop & hs → EMPTY.
    - otherwise hold.
  - TWO (count=2): no pop is possible.
    - hs → ONE, head <= skid.
    - otherwise hold.
- Order preservation: beats leave in the exact FIFO pop order. The skid entry always drains before any newer beat.
- Data stability: while o_valid=1 and i_ready=0, o_data, o_last and o_beat_cnt hold constant.
- Throughput: with the FIFO non-empty and i_ready=1, one beat per cycle in steady state.
- Latency: a pop in cycle N appears on o_valid/o_data in cycle N+1.
- Framing:
  - The beat counter increments on each hs and wraps BURST_LEN-1 → 0.
  - o_last = (o_beat_cnt == BURST_LEN-1) & o_valid.
  - The counter advances only on handshakes; FIFO stalls never break burst alignment.
- Unused data: when no pop occurs, the head and skid registers do not load. A gated-to-zero FIFO output while rd_en=0 is never sampled.
- o_level = count.

Test Plan:
- Basic drain: after reset, write 0x11,0x22,0x33 into the FIFO with i_ready=1 → o_valid rises one cycle after the first pop; o_data = 0x11,0x22,0x33 on consecutive cycles; o_beat_cnt = 0,1,2; o_last=0 throughout.
- Backpressure: FIFO holds 0xA0..0xA5, i_ready=0 for 5 cycles → o_level settles at 2; o_fifo_rd_en=0; o_data holds 0xA0. On i_ready=1: 0xA0..0xA5 emitted in order, one per cycle, with no gap.
- Burst framing (BURST_LEN=4): stream 10 beats 0..9 with i_ready toggling 1,0,1,0 → o_last high only on beats 3 and 7; o_beat_cnt wraps 3→0; beats 8,9 are indices 0,1.
- Pass-through: FIFO empty, write 0x5A in the same cycle the reader requests → pop occurs (FIFO empty=0 that cycle); 0x5A appears on o_data the next cycle. No combinational loop flagged by lint or simulation.
- Empty stall: FIFO goes empty mid-burst after beat index 1 and refills 4 cycles later → o_valid=0 during the gap; the next beat resumes at o_beat_cnt=2; no spurious or duplicated beat.
- Reset mid-operation: assert i_rst_n=0 with o_level=2 and o_beat_cnt=2 → all outputs are 0 immediately (asynchronously). After release, the first beat read from the FIFO has o_beat_cnt=0.
